led_scan_scheduler: RTL and testbench

//  Sequences and shares the 4-digit 7-segment display between two requesters (A, B).
//  Per frame: arbitrates ownership, snapshots the owner's 16-bit word, then scans digits 0..3.

---
 rtl/led_scan_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_led_scan_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_scheduler.sv
// ---------------------------------------------------------------------------
// led_scan_scheduler
//
// Shares one 4-digit multiplexed 7-segment display between two requesters,
// A and B. Each frame starts with a one-cycle arbitration step. That step
// picks the owner and captures the owner's 16-bit word. The frame then scans
// digits 0..3. Each digit slot is SCAN_DIV cycles long: BLANK_CYCLES with all
// anodes off (anti-ghosting), then a drive window for that digit.
//
// Frame length is 1 + 4*SCAN_DIV cycles.
//
// Parameters
//   SCAN_DIV      cycles per digit slot (blank + drive); must exceed BLANK_CYCLES
//   BLANK_CYCLES  all-off cycles at the start of each slot; 0 disables blanking
//   HOLD_FRAMES   frames an owner keeps the display while the other one waits
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset, synchronous release
//   req_a       in   requester A wants the display (level)
//   data_a      in   A's four chars, [3:0]=digit0 .. [15:12]=digit3
//   req_b       in   requester B wants the display (level)
//   data_b      in   B's four chars, same packing
//   gnt_a       out  A owns the current frame
//   gnt_b       out  B owns the current frame
//   an          out  anode enables, active-low one-hot, 4'hF = all off
//   char        out  nibble for the segment decoder, 0 while nothing is lit
//   blank       out  1 when no digit is lit this cycle
//   frame_done  out  one-cycle pulse on the last drive cycle of digit 3
// ---------------------------------------------------------------------------
module led_scan_scheduler #(
    parameter int SCAN_DIV     = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int HOLD_FRAMES  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  an,
    output logic [3:0]  char,
    output logic        blank,
    output logic        frame_done
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    // Every slot opens with the blanking gap unless blanking is disabled.
    localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [1:0]        idx, idx_n;
    owner_t            owner, owner_n;
    owner_t            last_owner, last_owner_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic [15:0]       snapshot, snapshot_n;

    logic   own_req;
    logic   other_req;
    owner_t other;
    logic   lit_n;

    // Request seen from the current owner's point of view.
    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        other     = OWN_A;
        case (owner)
            OWN_A: begin
                own_req   = req_a;
                other_req = req_b;
                other     = OWN_B;
            end
            OWN_B: begin
                own_req   = req_b;
                other_req = req_a;
                other     = OWN_A;
            end
            default: begin
                own_req   = 1'b0;
                other_req = 1'b0;
                other     = OWN_A;
            end
        endcase
    end

    // Next-state logic. Ownership and the snapshot only move in ST_ARB, so
    // they stay constant for the whole frame.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        idx_n        = idx;
        owner_n      = owner;
        last_owner_n = last_owner;
        hold_cnt_n   = hold_cnt;
        snapshot_n   = snapshot;

        case (state)
            ST_ARB: begin
                if (owner != OWN_NONE && own_req) begin
                    if (hold_cnt < HOLD_MAX) begin
                        hold_cnt_n = hold_cnt + 1'b1;
                    end else if (other_req) begin
                        owner_n    = other;
                        hold_cnt_n = HOLD_W'(1);
                    end
                    // Otherwise keep the owner; hold_cnt saturates at HOLD_MAX.
                end else begin
                    // Fresh grant. On a tie, the requester that did not own
                    // the display last time gets it.
                    if (req_a && req_b) begin
                        owner_n = (last_owner == OWN_A) ? OWN_B : OWN_A;
                    end else if (req_a) begin
                        owner_n = OWN_A;
                    end else if (req_b) begin
                        owner_n = OWN_B;
                    end else begin
                        owner_n = OWN_NONE;
                    end
                    hold_cnt_n = (owner_n == OWN_NONE) ? '0 : HOLD_W'(1);
                end

                if (owner_n != OWN_NONE) begin
                    last_owner_n = owner_n;
                end

                case (owner_n)
                    OWN_A:   snapshot_n = data_a;
                    OWN_B:   snapshot_n = data_b;
                    default: snapshot_n = 16'h0000;
                endcase

                cnt_n   = '0;
                idx_n   = 2'd0;
                state_n = SLOT_START;
            end

            ST_BLANK, ST_DRIVE: begin
                // cnt spans the whole slot: [0, BLANK_CYCLES) is the gap,
                // the rest is the drive window.
                if (cnt == LAST_CNT) begin
                    cnt_n = '0;
                    if (idx == 2'd3) begin
                        state_n = ST_ARB;
                    end else begin
                        idx_n   = idx + 2'd1;
                        state_n = SLOT_START;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (state == ST_BLANK && cnt == BLANK_LAST) begin
                        state_n = ST_DRIVE;
                    end
                end
            end

            default: begin
                state_n = ST_ARB;
            end
        endcase
    end

    // A digit is lit only in its drive window, and only for an owned frame.
    assign lit_n = (state_n == ST_DRIVE) && (owner_n != OWN_NONE);

    // State and registered outputs. The outputs are derived from the next
    // state, so each output matches the phase the FSM enters on this edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_ARB;
            cnt        <= '0;
            idx        <= 2'd0;
            owner      <= OWN_NONE;
            last_owner <= OWN_B;
            hold_cnt   <= '0;
            snapshot   <= 16'h0000;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            an         <= 4'hF;
            char       <= 4'h0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            hold_cnt   <= hold_cnt_n;
            snapshot   <= snapshot_n;
            gnt_a      <= (owner_n == OWN_A);
            gnt_b      <= (owner_n == OWN_B);
            an         <= lit_n ? ~(4'b0001 << idx_n) : 4'hF;
            char       <= lit_n ? snapshot_n[{idx_n, 2'b00} +: 4] : 4'h0;
            blank      <= ~lit_n;
            frame_done <= (state_n == ST_DRIVE) && (idx_n == 2'd3) &&
                          (cnt_n == LAST_CNT);
        end
    end

endmodule

// File: tb/tb_led_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_scan_scheduler
//
// Scoreboard bench for led_scan_scheduler. A frame-level reference model
// runs on each arbitration edge. It decides the owner from the request
// levels and queues one expected output word for each cycle of the coming
// frame. A separate monitor pops one expectation per cycle on the falling
// edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_led_scan_scheduler;

    localparam int SCAN_DIV     = 16;
    localparam int BLANK_CYCLES = 2;
    localparam int HOLD_FRAMES  = 4;
    localparam int FRAME        = 1 + 4 * SCAN_DIV;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [15:0] data_a = 16'h0000;
    logic [15:0] data_b = 16'h0000;
    logic        gnt_a, gnt_b, blank, frame_done;
    logic [3:0]  an, char;

    always #5 clock = ~clock;

    led_scan_scheduler #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .an        (an),
        .char      (char),
        .blank     (blank),
        .frame_done(frame_done)
    );

    // Observation word: {gnt_a, gnt_b, an[3:0], char[3:0], blank, frame_done}
    typedef logic [11:0] obs_t;
    localparam obs_t RESET_OBS = {1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0};

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Reference model state. Owner codes: 0 none, 1 A, 2 B.
    int          phase   = 0;
    int          m_owner = 0;
    int          m_last  = 2;
    int          m_hold  = 0;
    logic [15:0] m_word  = 16'h0000;
    bit          mon_on  = 1'b0;

    // Expected outputs t cycles after an arbitration edge (t = 1..FRAME).
    // t == FRAME is the next arbitration cycle, when everything is dark.
    function automatic obs_t expected_at(int t, int own, logic [15:0] word);
        int         slot;
        int         pos;
        bit         lit;
        logic [3:0] an_e;
        logic [3:0] ch_e;
        slot = (t - 1) / SCAN_DIV;
        pos  = (t - 1) % SCAN_DIV;
        lit  = (own != 0) && (t < FRAME) && (pos >= BLANK_CYCLES);
        an_e = 4'hF;
        ch_e = 4'h0;
        if (lit) begin
            an_e[slot] = 1'b0;
            ch_e       = word[4*slot +: 4];
        end
        return {own == 1, own == 2, an_e, ch_e, !lit, t == FRAME - 1};
    endfunction

    // Frame-level reference model.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase   = 0;
            m_owner = 0;
            m_last  = 2;
            m_hold  = 0;
            mon_on  = 1'b0;
            exp_q.delete();
        end else begin
            if (phase == 0) begin
                bit wants [3];
                wants[0] = 1'b0;
                wants[1] = req_a;
                wants[2] = req_b;
                if (m_owner != 0 && wants[m_owner]) begin
                    if (m_hold < HOLD_FRAMES) begin
                        m_hold = m_hold + 1;
                    end else if (wants[3 - m_owner]) begin
                        m_owner = 3 - m_owner;
                        m_hold  = 1;
                    end
                end else begin
                    if (req_a && req_b) m_owner = 3 - m_last;
                    else if (req_a)     m_owner = 1;
                    else if (req_b)     m_owner = 2;
                    else                m_owner = 0;
                    m_hold = (m_owner != 0) ? 1 : 0;
                end
                if (m_owner != 0) m_last = m_owner;
                m_word = (m_owner == 1) ? data_a : (m_owner == 2) ? data_b : 16'h0000;
                for (int t = 1; t <= FRAME; t++) begin
                    exp_q.push_back(expected_at(t, m_owner, m_word));
                end
                mon_on = 1'b1;
            end
            phase = (phase + 1) % FRAME;
        end
    end

    // Monitor: one comparison per cycle, sampled away from the rising edge.
    obs_t mon_act;
    obs_t mon_exp;
    always @(negedge clock) begin
        if (reset && mon_on) begin
            mon_act = {gnt_a, gnt_b, an, char, blank, frame_done};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t got=%03h", $time, mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL frame_out t=%0t phase=%0d got=%03h expected=%03h",
                             $time, phase, mon_act, mon_exp);
                end
            end
            checks++;
            if (gnt_a && gnt_b) begin
                errors++;
                $display("FAIL gnt_exclusive t=%0t got=11 expected=not 11", $time);
            end
        end
    end

    task automatic check_now(input string name, input obs_t expected);
        obs_t act;
        act = {gnt_a, gnt_b, an, char, blank, frame_done};
        checks++;
        if (act !== expected) begin
            errors++;
            $display("FAIL %s t=%0t got=%03h expected=%03h", name, $time, act, expected);
        end
    endtask

    // Modes: 0 idle, 1 only A with 1234, 2 both with random data,
    // 3 sporadic random request toggles, 5 A drops and changes data, B asks.
    task automatic drive_cycle(input int mode);
        @(negedge clock);
        #1;
        case (mode)
            0: begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            1: begin
                req_a  = 1'b1;
                req_b  = 1'b0;
                data_a = 16'h1234;
            end
            2: begin
                req_a  = 1'b1;
                req_b  = 1'b1;
                data_a = 16'($urandom);
                data_b = 16'($urandom);
            end
            3: begin
                if ($urandom_range(0, 19) == 0) req_a = ~req_a;
                if ($urandom_range(0, 19) == 0) req_b = ~req_b;
                data_a = 16'($urandom);
                data_b = 16'($urandom);
            end
            5: begin
                req_a  = 1'b0;
                req_b  = 1'b1;
                data_a = 16'hABCD;
                data_b = 16'($urandom);
            end
            default: begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
        endcase
    endtask

    task automatic run(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) drive_cycle(mode);
    endtask

    // Keep driving a mode until the model reaches a target phase, bounded.
    task automatic run_until_phase(input int mode, input int target, input string name);
        int n;
        n = 0;
        while (phase != target && n < 3 * FRAME) begin
            drive_cycle(mode);
            n++;
        end
        checks++;
        if (phase != target) begin
            errors++;
            $display("FAIL %s_timeout phase=%0d expected=%0d", name, phase, target);
        end
    endtask

    initial begin
        // Reset held low: every output at its reset value.
        repeat (2) @(negedge clock);
        #1 check_now("reset_hold_a", RESET_OBS);
        @(negedge clock);
        #1 check_now("reset_hold_b", RESET_OBS);

        // Release with no requests: arbitration cycle still dark, then blank frames.
        reset = 1'b1;
        #1 check_now("release_arb_cycle", RESET_OBS);
        run(3 * FRAME, 0);

        // Only A with 1234: fixed scan pattern.
        run(3 * FRAME, 1);

        // A owns, then mid-frame drops request and changes data; B asks.
        run_until_phase(1, 20, "midframe_sync");
        run(2 * FRAME, 5);

        // Both requesting: alternating ownership every HOLD_FRAMES frames.
        run(12 * FRAME, 2);

        // Sporadic random request changes.
        run(14 * FRAME, 3);

        // Only A for 10 frames, then B joins.
        run(10 * FRAME, 1);
        run(7 * FRAME, 2);

        // Reset during the digit-2 drive window: immediate dark outputs.
        run_until_phase(2, 40, "digit2_sync");
        #1 reset = 1'b0;
        #1 check_now("async_reset_mid_frame", RESET_OBS);
        @(negedge clock);
        #1 check_now("async_reset_held", RESET_OBS);
        reset = 1'b1;

        // Fresh start with both requesting: A must win the first arbitration.
        run(6 * FRAME, 2);

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
